// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor and keep the difference only when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] rem_in,
    input  logic         dvd_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem_in < divisor always holds, so the W+1-bit MSB of trial is a valid sign.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[W];
        rem_out = q_bit ? trial[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/divider_8bit_unit.sv
// Sequential unsigned divider with start/busy/done handshake, one quotient
// bit per clock; results and div_by_zero are registered and held.
module divider_8bit_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A_input,
    input  logic [DATA_W-1:0] B_input,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero
);

    localparam int CW = cnt_width(DATA_W);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] prem_q, prem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] step_rem;
    logic              step_qbit;

    div_step #(.W(DATA_W)) u_step (
        .rem_in  (prem_q),
        .dvd_msb (dvd_q[DATA_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = A_input;
                    dvs_d   = B_input;
                    prem_d  = '0;
                    cnt_d   = CW'(DATA_W);
                    state_d = CALC;
                end
            end
            CALC: begin
                prem_d = step_rem;
                dvd_d  = (dvd_q << 1) | DATA_W'(step_qbit);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero divisor naturally yields all-ones quotient and remainder = A.
                quo_d   = dvd_q;
                rem_d   = prem_q;
                dz_d    = (dvs_q == '0);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_divider_8bit_unit.sv
// Self-checking bench for divider_8bit_unit against an arithmetic reference model.
module tb_divider_8bit_unit;

    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A_input;
    logic [W-1:0] B_input;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    divider_8bit_unit #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A_input     (A_input),
        .B_input     (B_input),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output bit z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called just after a clock edge with the DUT idle; returns with the
    // done cycle visible (or after the cycle budget expired).
    task automatic do_div(input int a, input int b,
                          output int q, output int r, output bit z,
                          output int lat, output bit busy_ok);
        A_input = W'(a);
        B_input = W'(b);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        A_input = W'($urandom);
        B_input = W'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        q = int'(quotient);
        r = int'(remainder);
        z = div_by_zero;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic check_one(input string tag, input int a, input int b);
        int q, r, lat, eq, er;
        bit z, ez, bok;
        ref_div(a, b, eq, er, ez);
        do_div(a, b, q, r, z, lat, bok);
        $display("[TB] %s %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b, q, r, z, lat);
        n_tests++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency %0d/%0d: got %0d, required %0d", tag, a, b, lat, LAT);
        end
        n_tests++;
        if (q !== eq || r !== er || z !== ez) begin
            n_fail++;
            $display("FAIL %s_result %0d/%0d: got q=%0d r=%0d dz=%0d, required q=%0d r=%0d dz=%0d",
                     tag, a, b, q, r, z, eq, er, ez);
        end
        n_tests++;
        if (!bok) begin
            n_fail++;
            $display("FAIL %s_busy %0d/%0d: busy dropped before done, required high", tag, a, b);
        end
    endtask

    task automatic check_done_falls(input string tag);
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", tag, done);
        end
    endtask

    task automatic test_directed;
        check_one("dir", 15, 1);
        check_done_falls("dir");
        check_one("dir", 13, 4);
        check_one("dir", 3, 5);
        check_one("dir", 15, 15);
        check_done_falls("dir");
    endtask

    task automatic test_div_zero;
        check_one("dz", 7, 0);
        check_one("dz", 8, 2);
        check_done_falls("dz");
    endtask

    task automatic test_ignore_start;
        int pulses, q, r;
        bit z;
        pulses = 0; q = -1; r = -1; z = 1'b1;
        A_input = 4'd9; B_input = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        A_input = 4'd1; B_input = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                q = int'(quotient);
                r = int'(remainder);
                z = div_by_zero;
            end
            @(posedge clk); #1;
        end
        $display("[TB] ign 9/2 with restart -> q=%0d r=%0d dz=%0d pulses=%0d", q, r, z, pulses);
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL ignore_start_pulses: got %0d, required 1", pulses);
        end
        n_tests++;
        if (q !== 4 || r !== 1 || z !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_result: got q=%0d r=%0d dz=%0d, required q=4 r=1 dz=0", q, r, z);
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        pulses = 0;
        A_input = 4'd14; B_input = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", pulses);
        end
        check_one("abort", 14, 3);
        check_done_falls("abort");
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            check_one("rnd", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        end
        check_done_falls("rnd");
    endtask

    task automatic test_back_to_back;
        int q, r, lat, eq, er;
        bit z, ez, bok;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(a, b, eq, er, ez);
                do_div(a, b, q, r, z, lat, bok);
                n_tests++;
                if (lat !== LAT || q !== eq || r !== er || z !== ez || !bok) begin
                    n_fail++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d busy_ok=%0d, required q=%0d r=%0d dz=%0d lat=%0d busy_ok=1",
                             a, b, q, r, z, lat, bok, eq, er, ez, LAT);
                end
            end
        end
        $display("[TB] sweep of 256 back-to-back divides complete");
        check_done_falls("sweep");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A_input = '0; B_input = '0;
        repeat (3) begin @(posedge clk); #1; end
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
